// File: rtl/alu_sched_pkg.sv
// Purpose: shared opcode encodings, legality check and width defaults for the ALU scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_sched_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Opcodes 011, 100 and 101 have no ALU function behind them.
  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-way round-robin arbiter with a one-hot grant and a last-granted pointer.
// Latency: grant is combinational from req; pointer moves on the edge where accept is high.
// Backpressure: pointer holds while accept is low, so a stalled winner keeps its priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last;

  // Lone requester wins outright; on contention the one not granted last time wins.
  always_comb begin
    grant = req;
    if (&req) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Purpose: shares one external ALU between two valid/ready requesters through a single issue stage.
// Latency: request handshake at edge T, ALU driven in cycle T+1, response valid after edge T+1.
// Backpressure: a full response slot for the issuing requester stalls the issue stage and drops both req_ready.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [OP_W-1:0]   req_op_0,
  input  logic [DATA_W-1:0] req_x_0,
  input  logic [DATA_W-1:0] req_y_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [OP_W-1:0]   req_op_1,
  input  logic [DATA_W-1:0] req_x_1,
  input  logic [DATA_W-1:0] req_y_1,
  output logic              rsp_valid_0,
  input  logic              rsp_ready_0,
  output logic [DATA_W-1:0] rsp_data_0,
  output logic              rsp_zero_0,
  output logic              rsp_err_0,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_1,
  output logic [DATA_W-1:0] rsp_data_1,
  output logic              rsp_zero_1,
  output logic              rsp_err_1,
  output logic [OP_W-1:0]   alu_opcod,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);

  logic [1:0] req_vld;
  logic [1:0] rsp_rdy;
  logic [1:0] grant;
  logic       accept;
  logic       can_accept;
  logic       adv;

  logic              iss_valid;
  logic              iss_id;
  logic [OP_W-1:0]   iss_op;
  logic [DATA_W-1:0] iss_x;
  logic [DATA_W-1:0] iss_y;
  logic              iss_legal;

  logic [DATA_W-1:0] cap_data;
  logic              cap_zero;
  logic              cap_err;

  logic [1:0]             rsp_vld;
  logic [1:0][DATA_W-1:0] rsp_dat;
  logic [1:0]             rsp_zf;
  logic [1:0]             rsp_ef;

  assign req_vld = {req_valid_1, req_valid_0};
  assign rsp_rdy = {rsp_ready_1, rsp_ready_0};

  // The issue slot drains when its target response register is empty or being read this cycle.
  assign adv        = iss_valid & (~rsp_vld[iss_id] | rsp_rdy[iss_id]);
  assign can_accept = ~iss_valid | adv;
  assign accept     = can_accept & (|req_vld);

  assign req_ready_0 = can_accept & grant[0];
  assign req_ready_1 = can_accept & grant[1];

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_vld),
    .accept (accept),
    .grant  (grant)
  );

  // Issue register: load the granted request, otherwise empty out when the result is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_id    <= 1'b0;
      iss_op    <= '0;
      iss_x     <= '0;
      iss_y     <= '0;
    end else if (accept) begin
      iss_valid <= 1'b1;
      iss_id    <= grant[1];
      iss_op    <= grant[1] ? req_op_1 : req_op_0;
      iss_x     <= grant[1] ? req_x_1  : req_x_0;
      iss_y     <= grant[1] ? req_y_1  : req_y_0;
    end else if (adv) begin
      iss_valid <= 1'b0;
    end
  end

  assign iss_legal = op_legal(iss_op);

  // Idle or illegal slots present a quiet AND of zeros to the ALU.
  assign alu_opcod = (iss_valid & iss_legal) ? iss_op : '0;
  assign alu_x     = (iss_valid & iss_legal) ? iss_x  : '0;
  assign alu_y     = (iss_valid & iss_legal) ? iss_y  : '0;

  // Zero flag is meaningful only for SUB (compare); illegal ops return zero data with err set.
  assign cap_data = iss_legal ? alu_out : '0;
  assign cap_zero = iss_legal & (iss_op == OP_SUB) & alu_zero;
  assign cap_err  = ~iss_legal;

  for (genvar k = 0; k < 2; k++) begin : g_rsp
    localparam logic KID = 1'(k);

    // Response register k: a capture wins over a simultaneous read-out clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsp_vld[k] <= 1'b0;
        rsp_dat[k] <= '0;
        rsp_zf[k]  <= 1'b0;
        rsp_ef[k]  <= 1'b0;
      end else if (adv && (iss_id == KID)) begin
        rsp_vld[k] <= 1'b1;
        rsp_dat[k] <= cap_data;
        rsp_zf[k]  <= cap_zero;
        rsp_ef[k]  <= cap_err;
      end else if (rsp_rdy[k]) begin
        rsp_vld[k] <= 1'b0;
      end
    end
  end

  assign rsp_valid_0 = rsp_vld[0];
  assign rsp_data_0  = rsp_dat[0];
  assign rsp_zero_0  = rsp_zf[0];
  assign rsp_err_0   = rsp_ef[0];
  assign rsp_valid_1 = rsp_vld[1];
  assign rsp_data_1  = rsp_dat[1];
  assign rsp_zero_1  = rsp_zf[1];
  assign rsp_err_1   = rsp_ef[1];

endmodule

// File: tb/tb_alu_scheduler.sv
// Purpose: self-checking bench for alu_scheduler with a behavioural ALU beside it and a per-requester scoreboard.
// Latency: inputs change on the falling edge; handshakes are sampled just before each rising edge.
// Backpressure: rsp_ready is driven per scenario to exercise stalls and drains.
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic        z;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rv = '0;
  logic [1:0]  rr = '0;
  logic [2:0]  op [2];
  logic [15:0] x  [2];
  logic [15:0] y  [2];

  logic        req_ready_0, req_ready_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic [15:0] rsp_data_0, rsp_data_1;
  logic        rsp_zero_0, rsp_zero_1, rsp_err_0, rsp_err_1;
  logic [2:0]  alu_opcod;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zero;
  logic [74:0] all_out;

  int   checks = 0;
  int   errors = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  int   grants [$];
  logic [1:0] hs_seen = '0;

  always #5 clk = ~clk;

  alu_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(rv[0]), .req_ready_0(req_ready_0), .req_op_0(op[0]), .req_x_0(x[0]), .req_y_0(y[0]),
    .req_valid_1(rv[1]), .req_ready_1(req_ready_1), .req_op_1(op[1]), .req_x_1(x[1]), .req_y_1(y[1]),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rr[0]), .rsp_data_0(rsp_data_0),
    .rsp_zero_0(rsp_zero_0), .rsp_err_0(rsp_err_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rr[1]), .rsp_data_1(rsp_data_1),
    .rsp_zero_1(rsp_zero_1), .rsp_err_1(rsp_err_1),
    .alu_opcod(alu_opcod), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  assign all_out = {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1,
                    rsp_zero_0, rsp_zero_1, rsp_err_0, rsp_err_1, alu_opcod, alu_x, alu_y};

  // Behavioural ALU that sits beside the scheduler.
  always_comb begin
    case (alu_opcod)
      3'b000:  alu_out = alu_x & alu_y;
      3'b001:  alu_out = alu_x | alu_y;
      3'b010:  alu_out = alu_x + alu_y;
      3'b110:  alu_out = alu_x - alu_y;
      3'b111:  alu_out = ($signed(alu_x) < $signed(alu_y)) ? 16'd1 : 16'd0;
      default: alu_out = 16'd0;
    endcase
  end
  assign alu_zero = (alu_out == 16'd0);

  // Expected response for a request as seen by the requester.
  function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    r.z = 1'b0;
    r.e = 1'b0;
    case (o)
      3'b000:  r.d = a & b;
      3'b001:  r.d = a | b;
      3'b010:  r.d = a + b;
      3'b110:  begin r.d = a - b; r.z = (r.d == 16'd0); end
      3'b111:  r.d = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default: begin r.d = 16'd0; r.e = 1'b1; end
    endcase
    return r;
  endfunction

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #4;
    hs_seen = '0;
    if (rst_n) begin
      if (rv[0] && req_ready_0) begin q0.push_back(model(op[0], x[0], y[0])); grants.push_back(0); hs_seen[0] = 1'b1; end
      if (rv[1] && req_ready_1) begin q1.push_back(model(op[1], x[1], y[1])); grants.push_back(1); hs_seen[1] = 1'b1; end
      if (rsp_valid_0 && rr[0]) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL rsp0_unexpected: got data=%h with no outstanding request", rsp_data_0);
        end else begin
          e = q0.pop_front();
          if ({rsp_data_0, rsp_zero_0, rsp_err_0} !== e)
            begin errors++; $display("FAIL rsp0_data: got d=%h z=%b e=%b, want d=%h z=%b e=%b", rsp_data_0, rsp_zero_0, rsp_err_0, e.d, e.z, e.e); end
        end
      end
      if (rsp_valid_1 && rr[1]) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL rsp1_unexpected: got data=%h with no outstanding request", rsp_data_1);
        end else begin
          e = q1.pop_front();
          if ({rsp_data_1, rsp_zero_1, rsp_err_1} !== e)
            begin errors++; $display("FAIL rsp1_data: got d=%h z=%b e=%b, want d=%h z=%b e=%b", rsp_data_1, rsp_zero_1, rsp_err_1, e.d, e.z, e.e); end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h, want 0", all_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    rr = 2'b11;
    rv[0] = 1'b1; op[0] = OP_ADD; x[0] = 16'h0003; y[0] = 16'h0004;
    step();
    rv[0] = 1'b0;
    checks++;
    if (rsp_valid_0 !== 1'b0 || alu_opcod !== OP_ADD || alu_x !== 16'h0003 || alu_y !== 16'h0004) begin
      errors++;
      $display("FAIL latency_issue: got rsp_valid=%b op=%b x=%h y=%h, want 0 010 0003 0004", rsp_valid_0, alu_opcod, alu_x, alu_y);
    end
    step();
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_data_0 !== 16'h0007 || rsp_zero_0 !== 1'b0 || rsp_err_0 !== 1'b0) begin
      errors++;
      $display("FAIL latency_rsp: got v=%b d=%h z=%b e=%b, want 1 0007 0 0", rsp_valid_0, rsp_data_0, rsp_zero_0, rsp_err_0);
    end
    repeat (2) step();
  endtask

  task automatic test_round_robin();
    int exp_id;
    rr = 2'b11;
    op[0] = OP_SUB; x[0] = 16'd5; y[0] = 16'd5;
    op[1] = OP_SLT; x[1] = 16'd2; y[1] = 16'd9;
    grants.delete();
    rv = 2'b11;
    repeat (6) step();
    rv = 2'b00;
    checks++;
    if (grants.size() != 6) begin errors++; $display("FAIL rr_throughput: got %0d grants, want 6", grants.size()); end
    // Requester 0 was served last, so requester 1 takes the first contention.
    exp_id = 1;
    foreach (grants[i]) begin
      checks++;
      if (grants[i] != exp_id) begin errors++; $display("FAIL rr_order[%0d]: got %0d, want %0d", i, grants[i], exp_id); end
      exp_id = 1 - exp_id;
    end
    repeat (3) step();
  endtask

  task automatic test_stall();
    logic [15:0] base;
    logic [15:0] yv;
    logic [15:0] cnt;
    exp_t a;
    base = 16'h1234; yv = 16'h0F0F; cnt = 16'd0;
    a = model(OP_AND, base, yv);
    rr = 2'b10;
    rv[0] = 1'b1; op[0] = OP_AND; x[0] = base; y[0] = yv;
    for (int i = 0; i < 4; i++) begin
      step();
      if (hs_seen[0]) begin cnt = cnt + 16'd1; x[0] = base + cnt; end
      if (i >= 1) begin
        checks++;
        if (rsp_valid_0 !== 1'b1 || rsp_data_0 !== a.d || req_ready_0 !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold[%0d]: got v=%b d=%h rdy=%b, want 1 %h 0", i, rsp_valid_0, rsp_data_0, req_ready_0, a.d);
        end
      end
    end
    rr[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (hs_seen[0]) begin cnt = cnt + 16'd1; x[0] = base + cnt; end
    end
    rv[0] = 1'b0;
    repeat (4) step();
    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d pending, want 0", q0.size()); end
  endtask

  task automatic test_illegal();
    rr = 2'b11;
    rv[1] = 1'b1; op[1] = 3'b101; x[1] = 16'h0005; y[1] = 16'h0006;
    step();
    rv[1] = 1'b0;
    checks++;
    if (alu_opcod !== 3'b000 || alu_x !== 16'h0 || alu_y !== 16'h0) begin
      errors++;
      $display("FAIL illegal_alu: got op=%b x=%h y=%h, want 000 0000 0000", alu_opcod, alu_x, alu_y);
    end
    step();
    checks++;
    if (rsp_valid_1 !== 1'b1 || rsp_err_1 !== 1'b1 || rsp_data_1 !== 16'h0 || rsp_zero_1 !== 1'b0) begin
      errors++;
      $display("FAIL illegal_rsp: got v=%b e=%b d=%h z=%b, want 1 1 0000 0", rsp_valid_1, rsp_err_1, rsp_data_1, rsp_zero_1);
    end
    repeat (2) step();
  endtask

  task automatic test_wrap();
    rr = 2'b11;
    rv[0] = 1'b1; op[0] = OP_ADD; x[0] = 16'hFFFF; y[0] = 16'h0001;
    step();
    rv[0] = 1'b0;
    step();
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_data_0 !== 16'h0000 || rsp_zero_0 !== 1'b0 || rsp_err_0 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_add: got v=%b d=%h z=%b e=%b, want 1 0000 0 0", rsp_valid_0, rsp_data_0, rsp_zero_0, rsp_err_0);
    end
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    rr = 2'b00;
    rv[1] = 1'b1; op[1] = OP_OR; x[1] = 16'h0001; y[1] = 16'h0002;
    repeat (2) step();
    rv[1] = 1'b0;
    checks++;
    if (rsp_valid_1 !== 1'b1 || alu_opcod !== OP_OR) begin
      errors++;
      $display("FAIL reset_mid_setup: got rsp_valid_1=%b op=%b, want 1 001", rsp_valid_1, alu_opcod);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_mid_outputs: got %h, want 0", all_out); end
    q0.delete();
    q1.delete();
    step();
    rst_n = 1'b1;
    rr = 2'b11;
    op[0] = OP_ADD; x[0] = 16'h0010; y[0] = 16'h0020;
    op[1] = OP_ADD; x[1] = 16'h0100; y[1] = 16'h0200;
    grants.delete();
    rv = 2'b11;
    step();
    rv = 2'b00;
    checks++;
    if (grants.size() == 0) begin
      errors++;
      $display("FAIL reset_first_grant: got no grant, want 0");
    end else if (grants[0] != 0) begin
      errors++;
      $display("FAIL reset_first_grant: got %0d, want 0", grants[0]);
    end
    repeat (4) step();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin : main
    op[0] = '0; op[1] = '0;
    x[0]  = '0; x[1]  = '0;
    y[0]  = '0; y[1]  = '0;
    test_reset();
    test_latency();
    test_round_robin();
    test_stall();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
